// File: rtl/canny_pkg.sv
// rtl/canny_pkg.sv - shared types and frame-size helpers for the Canny frame sequencer
package canny_pkg;

    localparam int DATA_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_FEED,
        ST_DRAIN,
        ST_DONE
    } state_e;

    function automatic int in_pix(input int w, input int h);
        return w * h;
    endfunction

    // Each 3x3 window stage loses one row/column on every border.
    function automatic int out_pix(input int w, input int h, input int stages);
        return (w - 2 * stages) * (h - 2 * stages);
    endfunction

endpackage

// File: rtl/canny_pix_counter.sv
// rtl/canny_pix_counter.sv - raster column/row position counter with last-pixel flag
module canny_pix_counter #(
    parameter int W = 640,
    parameter int H = 512,
    localparam int CW = (W > 1) ? $clog2(W) : 1,
    localparam int RW = (H > 1) ? $clog2(H) : 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic last_o
);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          col_last;
    logic          row_last;

    assign col_last = (col_q == CW'(W - 1));
    assign row_last = (row_q == RW'(H - 1));
    assign last_o   = col_last & row_last;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clr_i) begin
            col_d = '0;
            row_d = '0;
        end else if (en_i) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/canny_frame_ctrl.sv
// rtl/canny_frame_ctrl.sv - per-frame flush/feed/drain sequencer in front of the Canny window pipeline
module canny_frame_ctrl
    import canny_pkg::*;
#(
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 512,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int STAGES    = 4,
    parameter int FLUSH_CYC = 4,
    parameter int DRAIN_TO  = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_start,
    input  logic              cfg_abort,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_ready,
    output logic              pipe_rst_n,
    output logic              pipe_enable,
    output logic [DATA_W-1:0] pipe_data,
    input  logic              pipe_ready,
    input  logic [DATA_W-1:0] pipe_out,
    output logic              dst_valid,
    output logic [DATA_W-1:0] dst_data,
    output logic              dst_last,
    output logic              busy,
    output logic              frame_done,
    output logic              err_overrun,
    output logic              err_timeout,
    output logic [15:0]       frame_cnt
);

    localparam int OUT_PIX = out_pix(IMG_W, IMG_H, STAGES);
    localparam int OC_W    = $clog2(OUT_PIX + 1);
    localparam int IDLE_W  = $clog2(DRAIN_TO + 1);
    localparam int FL_W    = $clog2(FLUSH_CYC + 1);

    state_e              state_q, state_d;
    logic [FL_W-1:0]     flush_q, flush_d;
    logic [OC_W-1:0]     out_cnt_q, out_cnt_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic                pipe_rst_n_q, pipe_rst_n_d;
    logic                pipe_enable_q, pipe_enable_d;
    logic [DATA_W-1:0]   pipe_data_q, pipe_data_d;
    logic                err_overrun_q, err_overrun_d;
    logic                err_timeout_q, err_timeout_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;

    logic abort_act;
    logic start_hit;
    logic src_hs;
    logic pix_last;
    logic out_full;
    logic timeout_hit;

    assign abort_act   = cfg_abort && (state_q != ST_IDLE);
    assign start_hit   = cfg_start && !cfg_abort && (state_q == ST_IDLE);
    // An aborting cycle must not swallow a source pixel that will never reach the pipeline.
    assign src_ready   = (state_q == ST_FEED) && !cfg_abort;
    assign src_hs      = src_valid && src_ready;
    assign out_full    = (out_cnt_q == OC_W'(OUT_PIX));
    assign timeout_hit = (state_q == ST_DRAIN) && !out_full && !cfg_abort
                         && (idle_q == IDLE_W'(DRAIN_TO));

    canny_pix_counter #(
        .W (IMG_W),
        .H (IMG_H)
    ) u_in_pos (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (state_q == ST_FLUSH),
        .en_i   (src_hs),
        .last_o (pix_last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_hit) state_d = ST_FLUSH;
            ST_FLUSH: if (flush_q == FL_W'(FLUSH_CYC - 1)) state_d = ST_FEED;
            ST_FEED:  if (src_hs && pix_last) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (out_full)         state_d = ST_DONE;
                else if (timeout_hit) state_d = ST_IDLE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (abort_act) state_d = ST_IDLE;
    end

    always_comb begin
        flush_d       = (state_q == ST_FLUSH) ? flush_q + 1'b1 : '0;
        pipe_rst_n_d  = (state_d != ST_FLUSH) && !abort_act;
        pipe_enable_d = src_hs;
        pipe_data_d   = src_hs ? src_data : pipe_data_q;

        out_cnt_d     = out_cnt_q;
        err_overrun_d = err_overrun_q;
        if (state_q == ST_FLUSH) begin
            out_cnt_d = '0;
        end else if (dst_valid) begin
            if (out_full) err_overrun_d = 1'b1;
            else          out_cnt_d     = out_cnt_q + 1'b1;
        end
        if (start_hit) err_overrun_d = 1'b0;

        // Idle count restarts on every pipeline strobe and whenever DRAIN is (re)entered.
        idle_d = idle_q;
        if (state_q != ST_DRAIN || pipe_ready) idle_d = '0;
        else if (idle_q != IDLE_W'(DRAIN_TO))  idle_d = idle_q + 1'b1;

        err_timeout_d = err_timeout_q;
        if (start_hit)        err_timeout_d = 1'b0;
        else if (timeout_hit) err_timeout_d = 1'b1;

        frame_cnt_d = frame_done ? frame_cnt_q + 16'd1 : frame_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            flush_q       <= '0;
            out_cnt_q     <= '0;
            idle_q        <= '0;
            pipe_rst_n_q  <= 1'b0;
            pipe_enable_q <= 1'b0;
            pipe_data_q   <= '0;
            err_overrun_q <= 1'b0;
            err_timeout_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            flush_q       <= flush_d;
            out_cnt_q     <= out_cnt_d;
            idle_q        <= idle_d;
            pipe_rst_n_q  <= pipe_rst_n_d;
            pipe_enable_q <= pipe_enable_d;
            pipe_data_q   <= pipe_data_d;
            err_overrun_q <= err_overrun_d;
            err_timeout_q <= err_timeout_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign pipe_rst_n  = pipe_rst_n_q;
    assign pipe_enable = pipe_enable_q;
    assign pipe_data   = pipe_data_q;
    assign dst_valid   = pipe_ready && ((state_q == ST_FEED) || (state_q == ST_DRAIN));
    assign dst_data    = pipe_out;
    assign dst_last    = dst_valid && (out_cnt_q == OC_W'(OUT_PIX - 1));
    assign busy        = (state_q != ST_IDLE);
    assign frame_done  = (state_q == ST_DONE) && !cfg_abort;
    assign err_overrun = err_overrun_q;
    assign err_timeout = err_timeout_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_canny_frame_ctrl.sv
// tb/tb_canny_frame_ctrl.sv - randomized self-checking bench for canny_frame_ctrl with a delay-line pipeline stub
module tb_canny_frame_ctrl;

    localparam int W    = 16;
    localparam int H    = 12;
    localparam int S    = 4;
    localparam int DW   = 16;
    localparam int NIN  = W * H;
    localparam int NOUT = (W - 2 * S) * (H - 2 * S);
    localparam int DTO  = 4096;
    localparam int LAT  = 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_start = 1'b0;
    logic          cfg_abort = 1'b0;
    logic          src_valid = 1'b0;
    logic [DW-1:0] src_data = '0;
    logic          src_ready, pipe_rst_n, pipe_enable, pipe_ready;
    logic          dst_valid, dst_last, busy, frame_done, err_overrun, err_timeout;
    logic [DW-1:0] pipe_data, pipe_out, dst_data;
    logic [15:0]   frame_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    canny_frame_ctrl #(
        .IMG_W(W), .IMG_H(H), .DATA_W(DW), .STAGES(S), .FLUSH_CYC(4), .DRAIN_TO(DTO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .pipe_rst_n(pipe_rst_n), .pipe_enable(pipe_enable), .pipe_data(pipe_data),
        .pipe_ready(pipe_ready), .pipe_out(pipe_out),
        .dst_valid(dst_valid), .dst_data(dst_data), .dst_last(dst_last),
        .busy(busy), .frame_done(frame_done), .err_overrun(err_overrun),
        .err_timeout(err_timeout), .frame_cnt(frame_cnt)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Raster index lies inside the region that survives all window stages.
    function automatic bit in_win(input int idx);
        int r, c;
        r = idx / W;
        c = idx % W;
        return (r >= S) && (r < H - S) && (c >= S) && (c < W - S);
    endfunction

    // Pipeline stub: mode 0 normal, 1 one extra output, 2 stops after 20 outputs.
    int            stub_mode = 0;
    int            stub_idx;
    int            stub_pushed;
    logic [LAT-1:0] dly_v;
    logic [DW-1:0] dly_d [LAT];
    logic          stub_take;

    always_comb begin
        stub_take = pipe_enable && (in_win(stub_idx) || (stub_mode == 1 && stub_idx == 124));
        if (stub_mode == 2 && stub_pushed >= 20) stub_take = 1'b0;
    end

    always @(posedge clk) begin
        if (!pipe_rst_n) begin
            dly_v       <= '0;
            stub_idx    <= 0;
            stub_pushed <= 0;
        end else begin
            dly_v <= {dly_v[LAT-2:0], stub_take};
            if (pipe_enable) stub_idx <= stub_idx + 1;
            if (stub_take) stub_pushed <= stub_pushed + 1;
        end
        dly_d[0] <= pipe_data;
        for (int i = 1; i < LAT; i++) dly_d[i] <= dly_d[i-1];
    end

    assign pipe_ready = dly_v[LAT-1];
    assign pipe_out   = dly_d[LAT-1] ^ 16'hA5A5;

    logic [DW-1:0] obs_q[$];
    int n_last   = 0;
    int last_pos = -1;
    int n_done   = 0;
    int n_pe     = 0;

    initial forever begin
        @(negedge clk);
        if (dst_valid) begin
            if (dst_last) begin
                n_last++;
                last_pos = obs_q.size();
            end
            obs_q.push_back(dst_data);
        end
        if (frame_done) n_done++;
        if (pipe_enable) n_pe++;
    end

    logic [DW-1:0] exp_q[$];
    int hs_n, tail, obs_base, done_base, pe_base, last_base;

    task automatic start_frame();
        @(posedge clk); #1 cfg_start = 1'b1;
        @(posedge clk); #1 cfg_start = 1'b0;
    endtask

    task automatic do_frame(input int pct, input int abort_at);
        int cyc, lim;
        cyc = 0;
        lim = (abort_at >= 0) ? abort_at : NIN;
        exp_q.delete();
        hs_n = 0; tail = 0;
        obs_base = obs_q.size(); done_base = n_done; pe_base = n_pe; last_base = n_last;
        while (hs_n < lim && cyc < 4000) begin
            @(posedge clk); #1;
            src_valid = ($urandom_range(99) < pct);
            src_data  = DW'($urandom);
            @(negedge clk);
            cyc++;
            if (src_valid && src_ready) begin
                if (in_win(hs_n)) exp_q.push_back(src_data ^ 16'hA5A5);
                hs_n++;
            end
        end
        chk("feed_handshakes", hs_n, lim);
        @(posedge clk); #1;
        src_valid = 1'b0;
        if (abort_at >= 0) begin
            cfg_abort = 1'b1;
            @(posedge clk); #1 cfg_abort = 1'b0;
        end else begin
            @(negedge clk);
            while (busy && tail < 6000) begin
                tail++;
                @(negedge clk);
            end
            chk("frame_ends_idle", busy, 0);
        end
    endtask

    task automatic check_data(input string tag);
        int mism, n;
        mism = 0;
        n = obs_q.size() - obs_base;
        if (n > exp_q.size()) n = exp_q.size();
        for (int i = 0; i < n; i++)
            if (obs_q[obs_base + i] !== exp_q[i]) mism++;
        chk(tag, mism, 0);
    endtask

    initial begin
        int nlow, cyc;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pipe_rst_n_low", pipe_rst_n, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_pipe_rst_n_high", pipe_rst_n, 1);
        chk("rst_src_ready", src_ready, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_errs", {err_overrun, err_timeout, dst_valid, pipe_enable}, 0);

        @(posedge clk); #1 begin cfg_start = 1'b1; cfg_abort = 1'b1; end
        @(posedge clk); #1 begin cfg_start = 1'b0; cfg_abort = 1'b0; end
        @(negedge clk);
        chk("start_abort_idle_busy", busy, 0);
        chk("start_abort_idle_rst", pipe_rst_n, 1);

        // Test 1: flush length, then test 2 on the same frame.
        start_frame();
        chk("t1_busy", busy, 1);
        nlow = 0; cyc = 0;
        while (!src_ready && cyc < 20) begin
            @(negedge clk);
            if (!pipe_rst_n) nlow++;
            cyc++;
        end
        chk("t1_flush_len", nlow, 4);
        chk("t1_src_ready", src_ready, 1);

        do_frame(100, -1);
        chk("t2_dst_count", obs_q.size() - obs_base, NOUT);
        chk("t2_last_count", n_last - last_base, 1);
        chk("t2_last_pos", last_pos - obs_base, NOUT - 1);
        chk("t2_done_count", n_done - done_base, 1);
        chk("t2_frame_cnt", frame_cnt, 1);
        chk("t2_errs", {err_overrun, err_timeout}, 0);
        check_data("t2_data");

        // Test 3: ~50% source gaps.
        start_frame();
        do_frame(50, -1);
        chk("t3_dst_count", obs_q.size() - obs_base, NOUT);
        chk("t3_pe_count", n_pe - pe_base, NIN);
        chk("t3_last_pos", last_pos - obs_base, NOUT - 1);
        chk("t3_done_count", n_done - done_base, 1);
        chk("t3_frame_cnt", frame_cnt, 2);
        check_data("t3_data");

        // Test 4: one output too many.
        stub_mode = 1;
        start_frame();
        do_frame(100, -1);
        chk("t4_dst_count", obs_q.size() - obs_base, NOUT + 1);
        chk("t4_overrun", err_overrun, 1);
        chk("t4_frame_cnt", frame_cnt, 3);
        stub_mode = 0;
        start_frame();
        chk("t4_overrun_clr", err_overrun, 0);
        do_frame(100, -1);
        chk("t4_frame_cnt2", frame_cnt, 4);

        // Test 5: outputs stop early, drain times out.
        stub_mode = 2;
        start_frame();
        do_frame(100, -1);
        chk("t5_dst_count", obs_q.size() - obs_base, 20);
        chk("t5_timeout", err_timeout, 1);
        chk("t5_drain_len", (tail >= DTO && tail <= DTO + 1), 1);
        chk("t5_no_done", n_done - done_base, 0);
        chk("t5_frame_cnt", frame_cnt, 4);
        stub_mode = 0;

        // Test 6: abort at pixel 100, then a clean frame.
        start_frame();
        chk("t6_timeout_clr", err_timeout, 0);
        do_frame(100, 100);
        @(negedge clk);
        chk("t6_busy", busy, 0);
        chk("t6_rst_pulse", pipe_rst_n, 0);
        @(negedge clk);
        chk("t6_rst_release", pipe_rst_n, 1);
        chk("t6_frame_cnt", frame_cnt, 4);
        chk("t6_no_done", n_done - done_base, 0);
        start_frame();
        do_frame(70, -1);
        chk("t6_dst_count", obs_q.size() - obs_base, NOUT);
        chk("t6_frame_cnt2", frame_cnt, 5);
        check_data("t6_data");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
